// File: rtl/video_frame_reader_if.sv
// Frame reader bus bundle: the synchronous-read memory port plus the
// vsync/href/gray pixel stream handed to the image processing chain.
interface video_frame_reader_if #(
   parameter int ADDR_W = 20
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [7:0]        mem_rd_data;
   logic              out_img_vsync;
   logic              out_img_href;
   logic [7:0]        out_img_gray;

   // The reader drives reads and the video stream; memory returns data.
   modport master (
      output mem_rd_en,
      output mem_rd_addr,
      input  mem_rd_data,
      output out_img_vsync,
      output out_img_href,
      output out_img_gray
   );

   // Memory/sink side of the same bundle.
   modport slave (
      input  mem_rd_en,
      input  mem_rd_addr,
      output mem_rd_data,
      input  out_img_vsync,
      input  out_img_href,
      input  out_img_gray
   );
endinterface

// File: rtl/video_frame_reader.sv
// Frame-buffer reader and video timing source. Walks a grayscale frame
// in raster order from a synchronous-read memory and emits it as a
// vsync/href/gray stream, two cycles behind the internal timing state.
module video_frame_reader #(
   parameter logic [10:0] IMG_HDISP = 11'd640,
   parameter logic [10:0] IMG_VDISP = 11'd480,
   parameter logic [15:0] H_BLANK   = 16'd160,
   parameter logic [15:0] V_PRE     = 16'd16,
   parameter logic [15:0] V_POST    = 16'd16,
   parameter logic [15:0] V_GAP     = 16'd64,
   parameter int          ADDR_W    = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   input  logic                  cont_mode,
   video_frame_reader_if.master  bus,
   output logic                  busy,
   output logic                  frame_done
);

   typedef enum logic [2:0] {
      IDLE,
      V_LEAD,
      LINE_ACT,
      LINE_BLK,
      V_TAIL,
      V_GAP_S
   } state_t;

   state_t            state_q;
   logic [10:0]       pixCnt_q;
   logic [10:0]       lineCnt_q;
   logic [15:0]       blkCnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic              vsync_q;
   logic              href_q;
   logic              busy_q;
   logic              frameDone_q;

   logic              vsyncDly_q;
   logic              hrefDly_q;
   logic              outVsync_q;
   logic              outHref_q;
   logic [7:0]        outGray_q;

   // Timing FSM: vsync/href/busy/frame_done are registered alongside the
   // state so they always match it; frame_done is raised one cycle early
   // so that it coincides with the last V_GAP_S cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pixCnt_q    <= 11'd0;
         lineCnt_q   <= 11'd0;
         blkCnt_q    <= 16'd0;
         addr_q      <= '0;
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         busy_q      <= 1'b0;
         frameDone_q <= 1'b0;
      end else begin
         frameDone_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (frame_start) begin
                  state_q   <= V_LEAD;
                  blkCnt_q  <= 16'd0;
                  lineCnt_q <= 11'd0;
                  addr_q    <= '0;
                  vsync_q   <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            V_LEAD: begin
               if (blkCnt_q == V_PRE - 16'd1) begin
                  state_q  <= LINE_ACT;
                  pixCnt_q <= 11'd0;
                  href_q   <= 1'b1;
               end else begin
                  blkCnt_q <= blkCnt_q + 16'd1;
               end
            end
            LINE_ACT: begin
               if ((pixCnt_q == IMG_HDISP - 11'd1) && (lineCnt_q == IMG_VDISP - 11'd1)) begin
                  addr_q <= '0;
               end else begin
                  addr_q <= addr_q + 1'b1;
               end
               if (pixCnt_q == IMG_HDISP - 11'd1) begin
                  state_q   <= LINE_BLK;
                  blkCnt_q  <= 16'd0;
                  href_q    <= 1'b0;
                  lineCnt_q <= lineCnt_q + 11'd1;
               end else begin
                  pixCnt_q <= pixCnt_q + 11'd1;
               end
            end
            LINE_BLK: begin
               if (blkCnt_q == H_BLANK - 16'd1) begin
                  if (lineCnt_q == IMG_VDISP) begin
                     state_q  <= V_TAIL;
                     blkCnt_q <= 16'd0;
                  end else begin
                     state_q  <= LINE_ACT;
                     pixCnt_q <= 11'd0;
                     href_q   <= 1'b1;
                  end
               end else begin
                  blkCnt_q <= blkCnt_q + 16'd1;
               end
            end
            V_TAIL: begin
               if (blkCnt_q == V_POST - 16'd1) begin
                  state_q     <= V_GAP_S;
                  blkCnt_q    <= 16'd0;
                  vsync_q     <= 1'b0;
                  frameDone_q <= (V_GAP == 16'd1);
               end else begin
                  blkCnt_q <= blkCnt_q + 16'd1;
               end
            end
            V_GAP_S: begin
               if (blkCnt_q == V_GAP - 16'd1) begin
                  if (cont_mode) begin
                     state_q   <= V_LEAD;
                     blkCnt_q  <= 16'd0;
                     lineCnt_q <= 11'd0;
                     addr_q    <= '0;
                     vsync_q   <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  blkCnt_q    <= blkCnt_q + 16'd1;
                  frameDone_q <= (blkCnt_q + 16'd1 == V_GAP - 16'd1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               vsync_q <= 1'b0;
               href_q  <= 1'b0;
            end
         endcase
      end
   end

   // Output pipeline: two stages of delay on vsync/href, and the memory
   // word captured one cycle after its read so it lands beside its href.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsyncDly_q <= 1'b0;
         hrefDly_q  <= 1'b0;
         outVsync_q <= 1'b0;
         outHref_q  <= 1'b0;
         outGray_q  <= 8'h00;
      end else begin
         vsyncDly_q <= vsync_q;
         hrefDly_q  <= href_q;
         outVsync_q <= vsyncDly_q;
         outHref_q  <= hrefDly_q;
         outGray_q  <= hrefDly_q ? bus.mem_rd_data : 8'h00;
      end
   end

   assign bus.mem_rd_en     = href_q;
   assign bus.mem_rd_addr   = addr_q;
   assign bus.out_img_vsync = outVsync_q;
   assign bus.out_img_href  = outHref_q;
   assign bus.out_img_gray  = outGray_q;
   assign busy              = busy_q;
   assign frame_done        = frameDone_q;

endmodule

// File: tb/tb_video_frame_reader.sv
// Bench for video_frame_reader: 4x3 frame, H_BLANK=2, V_PRE=3, V_POST=2,
// V_GAP=5, memory word = address + 0x10. A per-cycle table of expected
// outputs for one frame is replayed against single, continuous, mode-change
// and post-reset runs.
module tb_video_frame_reader;

   typedef struct packed {
      logic       rdEn;
      logic [3:0] addr;
      logic       vsync;
      logic       href;
      logic [7:0] gray;
      logic       busy;
      logic       done;
   } row_t;

   logic clk;
   logic rst_n;
   logic frame_start;
   logic cont_mode;
   logic busy;
   logic frame_done;

   int compared;
   int failed;
   int readCnt;
   int hrefCnt;
   int vsyncCnt;
   int doneCnt;

   row_t rows [0:30];

   video_frame_reader_if #(.ADDR_W(4)) bus ();

   video_frame_reader #(
      .IMG_HDISP (11'd4),
      .IMG_VDISP (11'd3),
      .H_BLANK   (16'd2),
      .V_PRE     (16'd3),
      .V_POST    (16'd2),
      .V_GAP     (16'd5),
      .ADDR_W    (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .cont_mode   (cont_mode),
      .bus         (bus),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   // Pixel clock.
   always #5 clk = ~clk;

   // Synchronous-read frame buffer holding address + 0x10.
   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
         bus.mem_rd_data <= 8'(bus.mem_rd_addr) + 8'h10;
      end
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic row_t mkRow(input int rd, input int a, input int vs,
                                  input int hr, input int g, input int b,
                                  input int d);
      row_t r;
      r.rdEn  = 1'(rd);
      r.addr  = 4'(a);
      r.vsync = 1'(vs);
      r.href  = 1'(hr);
      r.gray  = 8'(g);
      r.busy  = 1'(b);
      r.done  = 1'(d);
      return r;
   endfunction

   task automatic checkOutput(input string tag, input int idx, input row_t exp);
      row_t act;
      act.rdEn  = bus.mem_rd_en;
      act.addr  = bus.mem_rd_addr;
      act.vsync = bus.out_img_vsync;
      act.href  = bus.out_img_href;
      act.gray  = bus.out_img_gray;
      act.busy  = busy;
      act.done  = frame_done;
      if (act.rdEn)  readCnt++;
      if (act.href)  hrefCnt++;
      if (act.vsync) vsyncCnt++;
      if (act.done)  doneCnt++;
      compared++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s cycle %0d: got rd=%b addr=%0d vs=%b hr=%b gray=%h busy=%b done=%b, expected rd=%b addr=%0d vs=%b hr=%b gray=%h busy=%b done=%b",
                  tag, idx, act.rdEn, act.addr, act.vsync, act.href, act.gray, act.busy, act.done,
                  exp.rdEn, exp.addr, exp.vsync, exp.href, exp.gray, exp.busy, exp.done);
      end
   endtask

   task automatic checkCount(input string tag, input int act, input int exp);
      compared++;
      if (act != exp) begin
         failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // One request, nFrames frames compared cycle by cycle against the table,
   // with an optional frame_start pulse and an optional cont_mode drop.
   task automatic applyStimulus(input string tag, input int nFrames, input bit cont,
                                input int pulseFrame, input int pulseRow,
                                input int dropFrame, input int dropRow);
      readCnt  = 0;
      hrefCnt  = 0;
      vsyncCnt = 0;
      doneCnt  = 0;
      @(negedge clk);
      frame_start = 1'b1;
      cont_mode   = cont;
      for (int f = 0; f < nFrames; f++) begin
         for (int i = 1; i <= 28; i++) begin
            @(negedge clk);
            frame_start = 1'b0;
            checkOutput(tag, f * 28 + i, rows[i]);
            frame_start = (f == pulseFrame) && (i == pulseRow);
            if ((f == dropFrame) && (i == dropRow)) cont_mode = 1'b0;
         end
      end
      for (int i = 29; i <= 30; i++) begin
         @(negedge clk);
         frame_start = 1'b0;
         checkOutput(tag, nFrames * 28 + i - 28, rows[i]);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput({tag, "_idle"}, k, rows[30]);
      end
      cont_mode = 1'b0;
      checkCount({tag, "_reads"},  readCnt,  12 * nFrames);
      checkCount({tag, "_hrefs"},  hrefCnt,  12 * nFrames);
      checkCount({tag, "_vsyncs"}, vsyncCnt, 23 * nFrames);
      checkCount({tag, "_dones"},  doneCnt,  nFrames);
   endtask

   initial begin
      compared    = 0;
      failed      = 0;
      clk         = 1'b0;
      rst_n       = 1'b0;
      frame_start = 1'b0;
      cont_mode   = 1'b0;

      //             rd addr vs hr gray  busy done
      rows[0]  = mkRow(0,  0, 0, 0, 8'h00, 0, 0);
      rows[1]  = mkRow(0,  0, 0, 0, 8'h00, 1, 0);
      rows[2]  = mkRow(0,  0, 0, 0, 8'h00, 1, 0);
      rows[3]  = mkRow(0,  0, 1, 0, 8'h00, 1, 0);
      rows[4]  = mkRow(1,  0, 1, 0, 8'h00, 1, 0);
      rows[5]  = mkRow(1,  1, 1, 0, 8'h00, 1, 0);
      rows[6]  = mkRow(1,  2, 1, 1, 8'h10, 1, 0);
      rows[7]  = mkRow(1,  3, 1, 1, 8'h11, 1, 0);
      rows[8]  = mkRow(0,  4, 1, 1, 8'h12, 1, 0);
      rows[9]  = mkRow(0,  4, 1, 1, 8'h13, 1, 0);
      rows[10] = mkRow(1,  4, 1, 0, 8'h00, 1, 0);
      rows[11] = mkRow(1,  5, 1, 0, 8'h00, 1, 0);
      rows[12] = mkRow(1,  6, 1, 1, 8'h14, 1, 0);
      rows[13] = mkRow(1,  7, 1, 1, 8'h15, 1, 0);
      rows[14] = mkRow(0,  8, 1, 1, 8'h16, 1, 0);
      rows[15] = mkRow(0,  8, 1, 1, 8'h17, 1, 0);
      rows[16] = mkRow(1,  8, 1, 0, 8'h00, 1, 0);
      rows[17] = mkRow(1,  9, 1, 0, 8'h00, 1, 0);
      rows[18] = mkRow(1, 10, 1, 1, 8'h18, 1, 0);
      rows[19] = mkRow(1, 11, 1, 1, 8'h19, 1, 0);
      rows[20] = mkRow(0,  0, 1, 1, 8'h1A, 1, 0);
      rows[21] = mkRow(0,  0, 1, 1, 8'h1B, 1, 0);
      rows[22] = mkRow(0,  0, 1, 0, 8'h00, 1, 0);
      rows[23] = mkRow(0,  0, 1, 0, 8'h00, 1, 0);
      rows[24] = mkRow(0,  0, 1, 0, 8'h00, 1, 0);
      rows[25] = mkRow(0,  0, 1, 0, 8'h00, 1, 0);
      rows[26] = mkRow(0,  0, 0, 0, 8'h00, 1, 0);
      rows[27] = mkRow(0,  0, 0, 0, 8'h00, 1, 0);
      rows[28] = mkRow(0,  0, 0, 0, 8'h00, 1, 1);
      rows[29] = mkRow(0,  0, 0, 0, 8'h00, 0, 0);
      rows[30] = mkRow(0,  0, 0, 0, 8'h00, 0, 0);

      $display("[TB] reset state");
      repeat (2) @(negedge clk);
      checkOutput("reset", 0, rows[0]);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_idle", 0, rows[0]);

      $display("[TB] single frame, frame_start on the exit cycle");
      applyStimulus("single", 1, 1'b0, 0, 28, -1, 0);

      $display("[TB] continuous mode, three frames");
      applyStimulus("cont3", 3, 1'b1, -1, 0, 2, 10);

      $display("[TB] ignored frame_start and cont_mode drop");
      applyStimulus("ignore", 2, 1'b1, 0, 5, 1, 10);

      $display("[TB] reset mid-line");
      @(negedge clk);
      frame_start = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         frame_start = 1'b0;
         checkOutput("pre_rst", i, rows[i]);
      end
      @(posedge clk);
      #2;
      checkOutput("mid_pixel", 11, rows[11]);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst", 0, rows[0]);
      repeat (3) @(negedge clk);
      checkOutput("held_rst", 0, rows[0]);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checkOutput("post_rst_idle", k, rows[0]);
      end
      applyStimulus("after_rst", 1, 1'b0, -1, 0, -1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
